wb_bounded_responder: RTL
=========================

Name: wb_bounded_responder

Overview:
- Wishbone classic bridge between the core's bus master port (bus__*) and a downstream target (memory, peripheral or random responder).
- Registers every request and guarantees at least one wait state toward the core.
- Bounds downstream wait states: a target that never acks gets a timeout error response, so the core always makes progress.
- Counts timeouts so the fairness assumptions used in core verification become checkable hardware behaviour.

Parameters:
- MAX_WAIT, 4, maximum downstream cycles with dn__stb high before timeout; legal range 1..255.
- ERR_DATA, 32'hDEADBEEF, value returned on bus__dat_r for a timed-out transfer.
- CNT_WIDTH, 8, width of the saturating timeout counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- bus__adr  in  30  word address from core.
- bus__cyc  in  1  cycle valid from core.
- bus__stb  in  1  strobe from core.
- bus__we  in  1  write enable from core.
- bus__sel  in  4  byte selects from core.
- bus__dat_w  in  32  write data from core.
- bus__dat_r  out  32  read data to core.
- bus__ack  out  1  normal termination to core.
- bus__err  out  1  error termination to core (timeout).
- dn__adr  out  30  registered address to target.
- dn__cyc  out  1  cycle valid to target.
- dn__stb  out  1  strobe to target.
- dn__we  out  1  write enable to target.
- dn__sel  out  4  byte selects to target.
- dn__dat_w  out  32  write data to target.
- dn__dat_r  in  32  read data from target.
- dn__ack  in  1  ack from target.
- timeout  out  1  sticky flag: at least one timeout since reset.
- timeout_count  out  CNT_WIDTH  number of timeouts, saturating.

Behaviour:
Reset
- Async on rst high. State=IDLE; wait counter=0.
- All outputs 0: bus__dat_r, bus__ack, bus__err, dn__*, timeout, timeout_count.
- Reset asserted mid-transfer drops dn__cyc/dn__stb immediately; no ack or err is issued for the aborted transfer.

States: IDLE, WAIT, RESP.

IDLE
- On bus__cyc & bus__stb: latch adr/we/sel/dat_w into dn__* registers, clear wait counter, go to WAIT.
- dn__cyc = dn__stb = 0.
- bus__ack = bus__err = 0.

WAIT
- dn__cyc = dn__stb = 1, driving the latched request.
- On dn__ack: latch dn__dat_r into bus__dat_r (also for writes), set ok, go to RESP.
- Else if wait counter == MAX_WAIT-1: bus__dat_r <= ERR_DATA, set err, timeout <= 1, timeout_count += 1 (saturates at all-ones), go to RESP.
- Else: wait counter += 1.
- dn__ack wins when it coincides with the last allowed cycle.
- If bus__cyc drops (abort): go to IDLE next cycle with dn__cyc=0, no response, counters unchanged.

RESP
- Exactly one cycle of bus__ack=1 (ok) or bus__err=1 (timeout); never both.
- dn__cyc = dn__stb = 0.
- Next state is IDLE. A request still present is treated as new only from IDLE; per Wishbone the core must drop or renew stb after ack.
- bus__dat_r holds its value until the next RESP.

Timing
- Core request seen at cycle t0; dn__stb high at t0+1.
- Target ack at cycle tk gives bus__ack at tk+1.
- Minimum core latency is 2 cycles (bus__ack never in the cycle after the request).
- Maximum core latency is MAX_WAIT+1 cycles.

Other rules
- dn__ack in IDLE or RESP is ignored.
- The responder never asserts bus__ack or bus__err while bus__cyc is low.
- Wait counter width is clog2(MAX_WAIT)+1.

Test Plan:
- Read, target acks in its first WAIT cycle; dn__dat_r=32'h12345678 -> bus__ack 2 cycles after request, bus__dat_r=32'h12345678, bus__err=0.
- Write adr=30'h100, sel=4'b0011, dat_w=32'hA5A5A5A5; target acks after 3 cycles -> dn__* show the latched values throughout WAIT; one-cycle bus__ack at request+4.
- Target never acks, MAX_WAIT=4 -> dn__stb high for exactly 4 cycles; bus__err at request+5; bus__dat_r=32'hDEADBEEF; timeout=1; timeout_count=1.
- dn__ack arrives in the 4th (last) WAIT cycle -> bus__ack, not bus__err; timeout_count unchanged.
- 300 consecutive timeouts with CNT_WIDTH=8 -> timeout_count saturates at 255; timeout stays 1.
- Two boundary cases:
  - rst pulsed during WAIT -> all outputs 0 within the same cycle; no response afterwards.
  - bus__cyc dropped during WAIT -> back to IDLE; no ack or err issued.

Source files
------------

// File: rtl/wb_bounded_responder.sv
// wb_bounded_responder: registered Wishbone classic bridge with a bounded
// downstream wait. A target that never acks is answered with an error so the
// core always makes progress; timeouts are flagged and counted.
module wb_bounded_responder #(
   parameter int          MAX_WAIT  = 4,
   parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF,
   parameter int          CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [29:0]          bus__adr,
   input  logic                 bus__cyc,
   input  logic                 bus__stb,
   input  logic                 bus__we,
   input  logic [3:0]           bus__sel,
   input  logic [31:0]          bus__dat_w,
   output logic [31:0]          bus__dat_r,
   output logic                 bus__ack,
   output logic                 bus__err,
   output logic [29:0]          dn__adr,
   output logic                 dn__cyc,
   output logic                 dn__stb,
   output logic                 dn__we,
   output logic [3:0]           dn__sel,
   output logic [31:0]          dn__dat_w,
   input  logic [31:0]          dn__dat_r,
   input  logic                 dn__ack,
   output logic                 timeout,
   output logic [CNT_WIDTH-1:0] timeout_count
);

   localparam int             WCW       = $clog2(MAX_WAIT) + 1;
   localparam logic [WCW-1:0] LAST_WAIT = WCW'(MAX_WAIT - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t         state, state_nxt;
   logic [WCW-1:0] wait_cnt;
   logic           resp_ok, resp_err;
   logic           take_req, take_ack, take_to, wait_inc;

   // State register; reset lands in IDLE so dn__cyc/dn__stb drop at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and datapath control. Abort beats ack; ack beats timeout.
   always_comb begin
      state_nxt = state;
      take_req  = 1'b0;
      take_ack  = 1'b0;
      take_to   = 1'b0;
      wait_inc  = 1'b0;
      case (state)
         IDLE: begin
            if (bus__cyc && bus__stb) begin
               take_req  = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (!bus__cyc) begin
               state_nxt = IDLE;
            end else if (dn__ack) begin
               take_ack  = 1'b1;
               state_nxt = RESP;
            end else if (wait_cnt == LAST_WAIT) begin
               take_to   = 1'b1;
               state_nxt = RESP;
            end else begin
               wait_inc  = 1'b1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobe is decoded from the registered state, so it is glitch-free.
   assign dn__cyc  = (state == WAIT);
   assign dn__stb  = (state == WAIT);
   // Response only in RESP, and never toward a core that has dropped cyc.
   assign bus__ack = (state == RESP) && resp_ok  && bus__cyc;
   assign bus__err = (state == RESP) && resp_err && bus__cyc;

   // Request latch, wait counter, response capture and timeout bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dn__adr       <= '0;
         dn__we        <= 1'b0;
         dn__sel       <= '0;
         dn__dat_w     <= '0;
         bus__dat_r    <= '0;
         wait_cnt      <= '0;
         resp_ok       <= 1'b0;
         resp_err      <= 1'b0;
         timeout       <= 1'b0;
         timeout_count <= '0;
      end else begin
         if (take_req) begin
            dn__adr   <= bus__adr;
            dn__we    <= bus__we;
            dn__sel   <= bus__sel;
            dn__dat_w <= bus__dat_w;
            wait_cnt  <= '0;
         end
         if (wait_inc) wait_cnt <= wait_cnt + WCW'(1);
         if (take_ack) begin
            // Captured for writes too; the core ignores it then.
            bus__dat_r <= dn__dat_r;
            resp_ok    <= 1'b1;
            resp_err   <= 1'b0;
         end
         if (take_to) begin
            bus__dat_r <= ERR_DATA;
            resp_ok    <= 1'b0;
            resp_err   <= 1'b1;
            timeout    <= 1'b1;
            if (timeout_count != {CNT_WIDTH{1'b1}})
               timeout_count <= timeout_count + CNT_WIDTH'(1);
         end
      end
   end

endmodule
